// File: rtl/inverse_linear_interpolation_if.sv
// Request/response bundle for the inverse linear interpolator.
// The master drives the segment and target ordinate and consumes the result.
// The slave (the interpolator) answers with the computed abscissa.
interface inverse_linear_interpolation_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] x0;
  logic [DATA_WIDTH-1:0] y0;
  logic [DATA_WIDTH-1:0] x1;
  logic [DATA_WIDTH-1:0] y1;
  logic [DATA_WIDTH-1:0] y;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic                  out_valid;
  logic                  out_ready;
  logic                  degenerate;
  logic                  clamped;

  modport master (
    output x0, y0, x1, y1, y, in_valid, out_ready,
    input  in_ready, x, out_valid, degenerate, clamped
  );

  modport slave (
    input  x0, y0, x1, y1, y, in_valid, out_ready,
    output in_ready, x, out_valid, degenerate, clamped
  );
endinterface

// File: rtl/inverse_linear_interpolation.sv
// Inverse linear interpolation: given segment (x0,y0)-(x1,y1) and ordinate y,
// returns x = x0 + sgn(x1-x0) * floor(|y-y0|*|x1-x0| / |y1-y0|).
// Endpoint, out-of-range and flat segments short-circuit the divider; all
// other requests run a bit-serial restoring divider, one quotient bit per cycle.
module inverse_linear_interpolation #(
  parameter int DATA_WIDTH = 16
) (
  input logic                           clk,
  input logic                           rst,
  inverse_linear_interpolation_if.slave bus
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Captured request operands
  logic [DATA_WIDTH-1:0] x0_r, y0_r, x1_r, y1_r, y_r;

  // Divider state: partial remainder, unconsumed low product bits, quotient
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [DATA_WIDTH-2:0] quo_r;
  logic [CNT_W-1:0]      cnt_r;

  // Result registers
  logic [DATA_WIDTH-1:0] x_r;
  logic                  degenerate_r;
  logic                  clamped_r;

  // Setup-stage derived values
  logic [DATA_WIDTH-1:0] dy_abs_s, dyy_abs_s, dx_abs_s;
  logic [DATA_WIDTH-1:0] y_lo_s, y_hi_s;
  logic                  dx_neg_s;
  logic                  bypass_s;
  logic [DATA_WIDTH-1:0] bypass_x_s;
  logic                  bypass_deg_s;
  logic                  bypass_clamp_s;
  logic [PROD_W-1:0]     product_s;

  // Divider-step values
  logic [DATA_WIDTH:0]   trial_s;
  logic                  ge_s;
  logic [DATA_WIDTH-1:0] rem_next_s;
  logic [DATA_WIDTH-1:0] q_final_s;
  logic [DATA_WIDTH-1:0] div_x_s;

  // Magnitudes, direction and short-circuit classification of the captured request
  always_comb begin
    dy_abs_s       = '0;
    dyy_abs_s      = '0;
    dx_abs_s       = '0;
    y_lo_s         = '0;
    y_hi_s         = '0;
    bypass_s       = 1'b0;
    bypass_x_s     = x0_r;
    bypass_deg_s   = 1'b0;
    bypass_clamp_s = 1'b0;
    dx_neg_s       = (x1_r < x0_r);

    if (y1_r >= y0_r) begin
      dy_abs_s = y1_r - y0_r;
      y_lo_s   = y0_r;
      y_hi_s   = y1_r;
    end else begin
      dy_abs_s = y0_r - y1_r;
      y_lo_s   = y1_r;
      y_hi_s   = y0_r;
    end

    if (y_r >= y0_r) begin
      dyy_abs_s = y_r - y0_r;
    end else begin
      dyy_abs_s = y0_r - y_r;
    end

    if (dx_neg_s) begin
      dx_abs_s = x0_r - x1_r;
    end else begin
      dx_abs_s = x1_r - x0_r;
    end

    if (y0_r == y1_r) begin
      bypass_s     = 1'b1;
      bypass_x_s   = x0_r;
      bypass_deg_s = 1'b1;
    end else if ((y_r > y_hi_s) || (y_r < y_lo_s)) begin
      // Outside the segment: snap to whichever endpoint lies on y's side
      bypass_s       = 1'b1;
      bypass_clamp_s = 1'b1;
      if ((y_r > y_hi_s) == (y1_r > y0_r)) begin
        bypass_x_s = x1_r;
      end else begin
        bypass_x_s = x0_r;
      end
    end else if (y_r == y0_r) begin
      bypass_s   = 1'b1;
      bypass_x_s = x0_r;
    end else if (y_r == y1_r) begin
      bypass_s   = 1'b1;
      bypass_x_s = x1_r;
    end else begin
      bypass_s = 1'b0;
    end
  end

  assign product_s = PROD_W'(dyy_abs_s) * PROD_W'(dx_abs_s);

  // One restoring-division step; the remainder always stays below |dy|
  always_comb begin
    trial_s = {rem_r, lo_r[DATA_WIDTH-1]};
    ge_s    = (trial_s >= {1'b0, dy_abs_s});
    if (ge_s) begin
      rem_next_s = trial_s[DATA_WIDTH-1:0] - dy_abs_s;
    end else begin
      rem_next_s = trial_s[DATA_WIDTH-1:0];
    end
    q_final_s = {quo_r, ge_s};
    if (dx_neg_s) begin
      div_x_s = x0_r - q_final_s;
    end else begin
      div_x_s = x0_r + q_final_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (bypass_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DIV;
        end
      end
      DIV: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DIV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.x          = x_r;
    bus.degenerate = degenerate_r;
    bus.clamped    = clamped_r;
    case (state_r)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Operand capture, divider iteration and result update
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r         <= '0;
      y0_r         <= '0;
      x1_r         <= '0;
      y1_r         <= '0;
      y_r          <= '0;
      rem_r        <= '0;
      lo_r         <= '0;
      quo_r        <= '0;
      cnt_r        <= '0;
      x_r          <= '0;
      degenerate_r <= 1'b0;
      clamped_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            x0_r <= bus.x0;
            y0_r <= bus.y0;
            x1_r <= bus.x1;
            y1_r <= bus.y1;
            y_r  <= bus.y;
          end
        end
        SETUP: begin
          // Quotient fits DATA_WIDTH bits, so the high product half is already below |dy|
          rem_r <= product_s[PROD_W-1:DATA_WIDTH];
          lo_r  <= product_s[DATA_WIDTH-1:0];
          quo_r <= '0;
          cnt_r <= '0;
          if (bypass_s) begin
            x_r          <= bypass_x_s;
            degenerate_r <= bypass_deg_s;
            clamped_r    <= bypass_clamp_s;
          end
        end
        DIV: begin
          rem_r <= rem_next_s;
          lo_r  <= {lo_r[DATA_WIDTH-2:0], 1'b0};
          quo_r <= q_final_s[DATA_WIDTH-2:0];
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            x_r          <= div_x_s;
            degenerate_r <= 1'b0;
            clamped_r    <= 1'b0;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_linear_interpolation.sv
// Self-checking bench for inverse_linear_interpolation (DATA_WIDTH = 16).
module tb_inverse_linear_interpolation;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inverse_linear_interpolation_if #(.DATA_WIDTH(16)) bus ();

  inverse_linear_interpolation #(.DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] x0, y0, x1, y1, y;
    logic [15:0] ex;
    logic        ed, ec;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model written directly from the arithmetic definition
  task automatic model(input longint x0, y0, x1, y1, y,
                       output longint ex, output bit ed, output bit ec, output int lat);
    longint lo, hi, q;
    lo = (y0 < y1) ? y0 : y1;
    hi = (y0 < y1) ? y1 : y0;
    ed = 1'b0; ec = 1'b0; lat = 1;
    if (y0 == y1) begin
      ex = x0; ed = 1'b1;
    end else if (y < lo || y > hi) begin
      ec = 1'b1;
      ex = (absl(y - y1) < absl(y - y0)) ? x1 : x0;
    end else if (y == y0) begin
      ex = x0;
    end else if (y == y1) begin
      ex = x1;
    end else begin
      lat = 17;
      q   = (absl(y - y0) * absl(x1 - x0)) / absl(y1 - y0);
      ex  = (x1 >= x0) ? x0 + q : x0 - q;
    end
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x0 = 16'd0; bus.y0 = 16'd0; bus.x1 = 16'd0; bus.y1 = 16'd0; bus.y = 16'd0;
  endtask

  // Issue one request, measure latency, check result, optional backpressure hold
  task automatic run_req(input string name, input logic [15:0] x0, y0, x1, y1, y,
                         input longint ex, input bit ed, input bit ec, input int elat,
                         input int hold);
    int          waited;
    int          lat;
    bit          seen;
    logic [15:0] x_hold;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({name, " ready"}, longint'(bus.in_ready), 1);
    bus.x0 = x0; bus.y0 = y0; bus.x1 = x1; bus.y1 = y1; bus.y = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x0 = 16'($urandom); bus.y0 = 16'($urandom); bus.x1 = 16'($urandom);
    bus.y1 = 16'($urandom); bus.y = 16'($urandom);
    check({name, " busy"}, longint'(bus.in_ready), 0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check({name, " latency"}, lat, elat);
    check({name, " x"}, longint'(bus.x), ex);
    check({name, " degenerate"}, longint'(bus.degenerate), longint'(ed));
    check({name, " clamped"}, longint'(bus.clamped), longint'(ec));
    x_hold = bus.x;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold x"}, longint'(bus.x), longint'(x_hold));
      check({name, " hold valid"}, longint'(bus.out_valid), 1);
      check({name, " hold in_ready"}, longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " release valid"}, longint'(bus.out_valid), 0);
    check({name, " release ready"}, longint'(bus.in_ready), 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end

  initial begin
    longint ex;
    bit     ed, ec;
    int     lat;
    int     quiet;
    logic [15:0] rx0, ry0, rx1, ry1, ry, lo, hi;

    vecs[0]  = '{16'd0,     16'd0,    16'd10,    16'd100,   16'd50,    16'd5,     1'b0, 1'b0, 17};
    vecs[1]  = '{16'd0,     16'd1000, 16'd100,   16'd0,     16'd500,   16'd50,    1'b0, 1'b0, 17};
    vecs[2]  = '{16'd20,    16'd400,  16'd40,    16'd200,   16'd300,   16'd30,    1'b0, 1'b0, 17};
    vecs[3]  = '{16'd40,    16'd200,  16'd20,    16'd400,   16'd300,   16'd30,    1'b0, 1'b0, 17};
    vecs[4]  = '{16'd10,    16'd50,   16'd10,    16'd50,    16'd50,    16'd10,    1'b1, 1'b0, 1};
    vecs[5]  = '{16'd20,    16'd200,  16'd40,    16'd400,   16'd500,   16'd40,    1'b0, 1'b1, 1};
    vecs[6]  = '{16'd20,    16'd200,  16'd40,    16'd400,   16'd100,   16'd20,    1'b0, 1'b1, 1};
    vecs[7]  = '{16'd0,     16'd0,    16'd10,    16'd3,     16'd1,     16'd3,     1'b0, 1'b0, 17};
    vecs[8]  = '{16'd0,     16'd0,    16'd10,    16'd3,     16'd2,     16'd6,     1'b0, 1'b0, 17};
    vecs[9]  = '{16'd0,     16'd0,    16'd65535, 16'd1,     16'd1,     16'd65535, 1'b0, 1'b0, 1};
    vecs[10] = '{16'd5,     16'd10,   16'd100,   16'd20,    16'd10,    16'd5,     1'b0, 1'b0, 1};
    vecs[11] = '{16'd100,   16'd500,  16'd200,   16'd100,   16'd50,    16'd200,   1'b0, 1'b1, 1};
    vecs[12] = '{16'd0,     16'd0,    16'd65535, 16'd65535, 16'd32768, 16'd32768, 1'b0, 1'b0, 17};
    vecs[13] = '{16'd65535, 16'd0,    16'd0,     16'd65534, 16'd1,     16'd65534, 1'b0, 1'b0, 17};

    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("reset out_valid", longint'(bus.out_valid), 0);
    check("reset x", longint'(bus.x), 0);
    check("reset degenerate", longint'(bus.degenerate), 0);
    check("reset clamped", longint'(bus.clamped), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", longint'(bus.in_ready), 1);

    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].y,
              longint'(vecs[i].ex), vecs[i].ed, vecs[i].ec, vecs[i].lat, 0);
    end

    // Backpressure: result held for 5 cycles with out_ready low
    run_req("backpressure", 16'd0, 16'd0, 16'd10, 16'd100, 16'd50, 5, 1'b0, 1'b0, 17, 5);

    // Reset on edge 8 after accept aborts the divide
    bus.x0 = 16'd0; bus.y0 = 16'd0; bus.x1 = 16'd10; bus.y1 = 16'd100; bus.y = 16'd70;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out_valid", longint'(bus.out_valid), 0);
    check("abort x", longint'(bus.x), 0);
    check("abort degenerate", longint'(bus.degenerate), 0);
    check("abort clamped", longint'(bus.clamped), 0);
    check("abort in_ready", longint'(bus.in_ready), 1);
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) quiet++;
    end
    check("abort no output", quiet, 0);
    run_req("after abort", 16'd0, 16'd0, 16'd10, 16'd3, 16'd2, 6, 1'b0, 1'b0, 17, 0);

    // Reset wins over an accept on the same edge
    bus.x0 = 16'd10; bus.y0 = 16'd50; bus.x1 = 16'd10; bus.y1 = 16'd50; bus.y = 16'd50;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) quiet++;
    end
    check("rst priority no output", quiet, 0);
    check("rst priority in_ready", longint'(bus.in_ready), 1);

    // Random requests against the reference model (first 100 in range)
    for (int n = 0; n < 130; n++) begin
      rx0 = 16'($urandom_range(0, 65535));
      rx1 = 16'($urandom_range(0, 65535));
      ry0 = 16'($urandom_range(0, 65535));
      ry1 = 16'($urandom_range(0, 65535));
      lo  = (ry0 < ry1) ? ry0 : ry1;
      hi  = (ry0 < ry1) ? ry1 : ry0;
      if (n < 100) begin
        ry = lo + 16'($urandom_range(0, int'(hi - lo)));
      end else begin
        ry = 16'($urandom_range(0, 65535));
      end
      model(longint'(rx0), longint'(ry0), longint'(rx1), longint'(ry1), longint'(ry),
            ex, ed, ec, lat);
      run_req($sformatf("rand%0d", n), rx0, ry0, rx1, ry1, ry, ex, ed, ec, lat, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inverse_linear_interpolation.md
INVERSE_LINEAR_INTERPOLATION -- requirements
Module: inverse_linear_interpolation

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning width of all x/y operands and result (unsigned).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports x0, y0, x1, y1  input  DATA_WIDTH each  segment endpoints (x0,y0),(x1,y1).
REQ-005 SHALL have port y  input  DATA_WIDTH  target ordinate whose abscissa is requested.
REQ-006 SHALL have port in_valid  input  1  request qualifier; in_ready  output  1  block can accept.
REQ-007 SHALL have port x  output  DATA_WIDTH  computed abscissa.
REQ-008 SHALL have port out_valid  output  1  result qualifier; out_ready  input  1  consumer accepts.
REQ-009 SHALL have port degenerate  output  1  y0==y1 for the returned result.
REQ-010 SHALL have port clamped  output  1  y lay outside [min(y0,y1), max(y0,y1)].

Function
REQ-011 SHALL compute x = x0 + sgn(x1-x0) * floor(|y-y0| * |x1-x0| / |y1-y0|), exact integer, truncation toward x0.
REQ-012 SHALL capture x0,y0,x1,y1,y on the edge where in_valid && in_ready (accept edge); inputs otherwise ignored.
REQ-013 SHALL implement states IDLE, SETUP, DIV, DONE; in_ready = 1 only in IDLE.
REQ-014 IDLE -> SETUP on accept edge; SETUP computes |dy|, |y-y0|, |dx|, direction, special cases.
REQ-015 SETUP -> DONE directly (bypass) when: y0==y1 (x=x0, degenerate=1); y beyond y1 side (x=x1, clamped=1); y beyond y0 side (x=x0, clamped=1); y==y0 (x=x0); y==y1 (x=x1).
REQ-016 Otherwise SETUP -> DIV; DIV SHALL run a restoring divider on the 2*DATA_WIDTH-bit product |y-y0|*|dx| by |dy|, one quotient bit per cycle, exactly DATA_WIDTH cycles, then -> DONE.
REQ-017 Quotient SHALL fit DATA_WIDTH bits (|y-y0| < |dy| guarantees q < |dx|); no overflow handling required; x = x0+q or x0-q never wraps.
REQ-018 Latency: out_valid first high after edge DATA_WIDTH+1 following the accept edge for divider path (17 for DATA_WIDTH=16); after edge 1 for bypass path.
REQ-019 out_valid = 1 only in DONE; x, degenerate, clamped SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 DONE -> IDLE on edge with out_ready=1; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-021 Outputs x, degenerate, clamped SHALL hold last result values in IDLE/SETUP/DIV; only out_valid qualifies them.
REQ-022 Input changes while busy SHALL not affect the in-flight result.

Reset
REQ-023 rst=1 on an edge SHALL force state IDLE, out_valid=0, x=0, degenerate=0, clamped=0, divider registers and counter=0, from any state including mid-DIV; in_ready=1 the cycle after rst deasserts.
REQ-024 rst SHALL take priority over accept and out_ready on the same edge; aborted requests SHALL produce no output.

Verification
REQ-025 (0,0)-(10,100), y=50 -> x=5, degenerate=0, clamped=0, out_valid after edge 17 post-accept.
REQ-026 (0,1000)-(100,0), y=500 -> x=50; (20,400)-(40,200), y=300 -> x=30 (falling dx sign checked via (40,200)-(20,400), y=300 -> x=30).
REQ-027 (10,50)-(10,50), y=50 -> x=10, degenerate=1, latency 1; (20,200)-(40,400), y=500 -> x=40, clamped=1; y=100 -> x=20, clamped=1.
REQ-028 Truncation: (0,0)-(10,3), y=1 -> x=3; y=2 -> x=6; (0,0)-(65535,1)... y=1 bypass -> x=65535.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> x stable, in_ready=0; then out_ready=1 -> IDLE, next request accepted one cycle later; back-to-back 100 random in-range requests match REQ-011 model.
REQ-030 Reset mid-DIV (rst at edge 8 post-accept) -> out_valid never asserts for that request, all outputs 0, next request yields correct result.
